// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-file widths, types and round-robin index
//               helpers for the write-back scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int NUM_REGISTERS = 32;
  localparam int REG_IDX_WIDTH = $clog2(NUM_REGISTERS);

  typedef logic [REG_IDX_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]    reg_data_t;

  // (base + off) mod n, for 0 <= base, off < n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return rr_wrap(idx, 1, n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_sched_if
// Description : Issue-side reserve/query, write-back requester and
//               register-file write bundle for the write-back scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_sched_if #(
  parameter int NUM_REQ       = 3,
  parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
  parameter int REG_IDX_WIDTH = regfile_pkg::REG_IDX_WIDTH
);

  // Issue-stage reservation and operand queries
  logic                                       reserve_valid;
  logic [REG_IDX_WIDTH-1:0]                   reserve_reg;
  logic                                       reserve_ready;
  logic [REG_IDX_WIDTH-1:0]                   query_reg_1;
  logic [REG_IDX_WIDTH-1:0]                   query_reg_2;
  logic                                       query_busy_1;
  logic                                       query_busy_2;

  // Write-back requesters
  logic [NUM_REQ-1:0]                         req_valid;
  logic [NUM_REQ-1:0][REG_IDX_WIDTH-1:0]      req_reg;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]         req_data;
  logic [NUM_REQ-1:0]                         req_ready;

  // Register-file write port and error flag
  logic [REG_IDX_WIDTH-1:0]                   rf_write_register;
  logic [DATA_WIDTH-1:0]                      rf_write_data;
  logic                                       rf_write_data_valid;
  logic                                       wb_unreserved_err;

  modport master (
    output reserve_valid, reserve_reg, query_reg_1, query_reg_2,
           req_valid, req_reg, req_data,
    input  reserve_ready, query_busy_1, query_busy_2, req_ready,
           rf_write_register, rf_write_data, rf_write_data_valid,
           wb_unreserved_err
  );

  modport slave (
    input  reserve_valid, reserve_reg, query_reg_1, query_reg_2,
           req_valid, req_reg, req_data,
    output reserve_ready, query_busy_1, query_busy_2, req_ready,
           rf_write_register, rf_write_data, rf_write_data_valid,
           wb_unreserved_err
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; one-hot grant searched upward from an
//               internal pointer that moves just past each winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic [N-1:0] req,
  output logic      [N-1:0] grant
);

  localparam int c_ptr_w = $clog2(N);

  logic [c_ptr_w-1:0] r_ptr;
  logic [c_ptr_w-1:0] w_ptr_next;
  logic [N-1:0]       w_grant;
  logic               w_found;
  int                 w_win;

  // First requester at or after the pointer, wrapping around the ring.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_win   = 0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[rr_wrap(int'(r_ptr), k, N)]) begin
        w_found = 1'b1;
        w_win   = rr_wrap(int'(r_ptr), k, N);
      end
    end
    if (w_found) w_grant[w_win] = 1'b1;
    w_ptr_next = w_found ? c_ptr_w'(rr_next(w_win, N)) : r_ptr;
  end

  // Pointer advances past the winner; holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_next;
  end

  assign grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_sched
// Description : Register scoreboard plus round-robin write-back scheduler
//               feeding a single register-file write port (latency 1).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
  parameter int NUM_REQ       = 3,
  parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
  parameter int REG_IDX_WIDTH = regfile_pkg::REG_IDX_WIDTH
) (
  input wire logic          clk,
  input wire logic          rst,
  regfile_wb_sched_if.slave bus
);

  localparam int c_num_regs = 1 << REG_IDX_WIDTH;

  logic [c_num_regs-1:0]    r_busy;
  logic                     r_rf_valid;
  logic [REG_IDX_WIDTH-1:0] r_rf_reg;
  logic [DATA_WIDTH-1:0]    r_rf_data;
  logic                     r_err;

  logic [NUM_REQ-1:0]       w_arb_req;
  logic [NUM_REQ-1:0]       w_grant;
  logic                     w_hs;
  logic [REG_IDX_WIDTH-1:0] w_sel_reg;
  logic [DATA_WIDTH-1:0]    w_sel_data;
  logic                     w_clear_hit;
  logic                     w_reserve_ready;
  logic                     w_do_set;
  logic                     w_unreserved;

  // Requests are masked during reset so no grant is issued.
  assign w_arb_req = rst ? '0 : bus.req_valid;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (w_arb_req),
    .grant (w_grant)
  );

  assign w_hs = |w_grant;

  // Route the granted requester's destination and data.
  always_comb begin
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_reg  = bus.req_reg[k];
        w_sel_data = bus.req_data[k];
      end
    end
  end

  // A clear is in flight for the reservation target if it is being written
  // back now or is on the register-file port now; stalling here keeps a set
  // from colliding with (or being wiped by) the pending clear.
  assign w_clear_hit = (r_rf_valid && (r_rf_reg == bus.reserve_reg)) ||
                       (w_hs && (w_sel_reg == bus.reserve_reg));

  assign w_reserve_ready = !rst &&
                           ((bus.reserve_reg == '0) ||
                            (!r_busy[bus.reserve_reg] && !w_clear_hit));

  assign w_do_set     = bus.reserve_valid && w_reserve_ready && (bus.reserve_reg != '0);
  assign w_unreserved = w_hs && (w_sel_reg != '0) && !r_busy[w_sel_reg];

  // Scoreboard: clear on register-file write, set on accepted reservation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (r_rf_valid) r_busy[r_rf_reg] <= 1'b0;
      if (w_do_set)   r_busy[bus.reserve_reg] <= 1'b1;
    end
  end

  // Register-file write port: one-cycle pipeline of the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_valid <= 1'b0;
      r_rf_reg   <= '0;
      r_rf_data  <= '0;
    end else begin
      r_rf_valid <= w_hs;
      if (w_hs) begin
        r_rf_reg  <= w_sel_reg;
        r_rf_data <= w_sel_data;
      end
    end
  end

  // Sticky flag for write-backs to registers nobody reserved.
  always_ff @(posedge clk) begin
    if (rst)               r_err <= 1'b0;
    else if (w_unreserved) r_err <= 1'b1;
  end

  assign bus.reserve_ready       = w_reserve_ready;
  assign bus.query_busy_1        = r_busy[bus.query_reg_1];
  assign bus.query_busy_2        = r_busy[bus.query_reg_2];
  assign bus.req_ready           = w_grant;
  assign bus.rf_write_register   = r_rf_reg;
  assign bus.rf_write_data       = r_rf_data;
  assign bus.rf_write_data_valid = r_rf_valid;
  assign bus.wb_unreserved_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_regfile_wb_sched
// Description : Self-checking bench for regfile_wb_sched: directed scenarios
//               and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_sched;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  regfile_wb_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .REG_IDX_WIDTH(RW)) bus ();

  regfile_wb_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .REG_IDX_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reserve_valid = 1'b0;
    bus.reserve_reg   = '0;
    bus.query_reg_1   = '0;
    bus.query_reg_2   = '0;
    bus.req_valid     = '0;
    bus.req_reg       = '0;
    bus.req_data      = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.req_valid     = 3'b111;
    bus.reserve_valid = 1'b1;
    bus.reserve_reg   = 5'd5;
    bus.query_reg_1   = 5'd5;
    #1;
    tests++; if (bus.req_ready !== 3'b000) begin fails++; $display("FAIL rst_req_ready: got %b expected 000", bus.req_ready); end
    tests++; if (bus.reserve_ready !== 1'b0) begin fails++; $display("FAIL rst_reserve_ready: got %b expected 0", bus.reserve_ready); end
    cyc();
    cyc();
    rst = 1'b0;
    bus.req_valid     = '0;
    bus.reserve_valid = 1'b0;
    #1;
    tests++; if (bus.rf_write_data_valid !== 1'b0) begin fails++; $display("FAIL rst_rf_valid: got %b expected 0", bus.rf_write_data_valid); end
    tests++; if (bus.rf_write_register !== 5'd0) begin fails++; $display("FAIL rst_rf_reg: got %0d expected 0", bus.rf_write_register); end
    tests++; if (bus.rf_write_data !== 32'd0) begin fails++; $display("FAIL rst_rf_data: got %h expected 0", bus.rf_write_data); end
    tests++; if (bus.wb_unreserved_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", bus.wb_unreserved_err); end
    tests++; if (bus.query_busy_1 !== 1'b0) begin fails++; $display("FAIL rst_busy5: got %b expected 0", bus.query_busy_1); end
  endtask

  task automatic test_reserve_query();
    do_reset();
    bus.reserve_valid = 1'b1;
    bus.reserve_reg   = 5'd5;
    bus.query_reg_1   = 5'd5;
    #1;
    tests++; if (bus.reserve_ready !== 1'b1) begin fails++; $display("FAIL rsv_first_ready: got %b expected 1", bus.reserve_ready); end
    tests++; if (bus.query_busy_1 !== 1'b0) begin fails++; $display("FAIL rsv_busy_before: got %b expected 0", bus.query_busy_1); end
    cyc();
    #1;
    tests++; if (bus.query_busy_1 !== 1'b1) begin fails++; $display("FAIL rsv_busy_after: got %b expected 1", bus.query_busy_1); end
    tests++; if (bus.reserve_ready !== 1'b0) begin fails++; $display("FAIL rsv_second_ready: got %b expected 0", bus.reserve_ready); end
    bus.reserve_reg = 5'd0;
    #1;
    tests++; if (bus.reserve_ready !== 1'b1) begin fails++; $display("FAIL rsv_r0_ready: got %b expected 1", bus.reserve_ready); end
    idle();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req_valid = 3'b111;
    for (int k = 0; k < NR; k++) begin
      bus.req_reg[k]  = 5'(k + 1);
      bus.req_data[k] = 32'h100 + 32'(k);
    end
    for (int c = 0; c < 7; c++) begin
      #1;
      tests++;
      if (bus.req_ready !== 3'(1 << (c % NR))) begin
        fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, bus.req_ready, 3'(1 << (c % NR)));
      end
      if (c > 0) begin
        tests++;
        if (bus.rf_write_data_valid !== 1'b1 || bus.rf_write_register !== 5'(((c - 1) % NR) + 1) ||
            bus.rf_write_data !== 32'h100 + 32'((c - 1) % NR)) begin
          fails++; $display("FAIL rr_rf[%0d]: got v=%b r=%0d d=%h expected v=1 r=%0d d=%h", c,
                            bus.rf_write_data_valid, bus.rf_write_register, bus.rf_write_data,
                            ((c - 1) % NR) + 1, 32'h100 + 32'((c - 1) % NR));
        end
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_writeback_clear();
    do_reset();
    bus.reserve_valid = 1'b1;
    bus.reserve_reg   = 5'd7;
    cyc();
    bus.reserve_valid = 1'b0;
    bus.req_valid     = 3'b010;
    bus.req_reg[1]    = 5'd7;
    bus.req_data[1]   = 32'hDEADBEEF;
    bus.query_reg_1   = 5'd7;
    #1;
    tests++; if (bus.req_ready !== 3'b010) begin fails++; $display("FAIL wb_grant: got %b expected 010", bus.req_ready); end
    tests++; if (bus.query_busy_1 !== 1'b1) begin fails++; $display("FAIL wb_busy_pre: got %b expected 1", bus.query_busy_1); end
    cyc();
    bus.req_valid = '0;
    #1;
    tests++;
    if (bus.rf_write_data_valid !== 1'b1 || bus.rf_write_register !== 5'd7 || bus.rf_write_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL wb_rf: got v=%b r=%0d d=%h expected v=1 r=7 d=deadbeef",
                        bus.rf_write_data_valid, bus.rf_write_register, bus.rf_write_data);
    end
    tests++; if (bus.query_busy_1 !== 1'b1) begin fails++; $display("FAIL wb_busy_mid: got %b expected 1", bus.query_busy_1); end
    cyc();
    #1;
    tests++; if (bus.query_busy_1 !== 1'b0) begin fails++; $display("FAIL wb_busy_cleared: got %b expected 0", bus.query_busy_1); end
    tests++; if (bus.rf_write_data_valid !== 1'b0) begin fails++; $display("FAIL wb_rf_idle: got %b expected 0", bus.rf_write_data_valid); end
    tests++; if (bus.rf_write_data !== 32'hDEADBEEF) begin fails++; $display("FAIL wb_rf_hold: got %h expected deadbeef", bus.rf_write_data); end
    tests++; if (bus.wb_unreserved_err !== 1'b0) begin fails++; $display("FAIL wb_err: got %b expected 0", bus.wb_unreserved_err); end
    idle();
  endtask

  task automatic test_unreserved_err();
    do_reset();
    bus.req_valid   = 3'b001;
    bus.req_reg[0]  = 5'd9;
    bus.req_data[0] = 32'h00001234;
    cyc();
    bus.req_valid = '0;
    #1;
    tests++;
    if (bus.rf_write_data_valid !== 1'b1 || bus.rf_write_register !== 5'd9 || bus.rf_write_data !== 32'h1234) begin
      fails++; $display("FAIL unres_fwd: got v=%b r=%0d d=%h expected v=1 r=9 d=1234",
                        bus.rf_write_data_valid, bus.rf_write_register, bus.rf_write_data);
    end
    tests++; if (bus.wb_unreserved_err !== 1'b1) begin fails++; $display("FAIL unres_err_set: got %b expected 1", bus.wb_unreserved_err); end
    cyc();
    cyc();
    #1;
    tests++; if (bus.wb_unreserved_err !== 1'b1) begin fails++; $display("FAIL unres_err_sticky: got %b expected 1", bus.wb_unreserved_err); end
    do_reset();
    bus.req_valid   = 3'b100;
    bus.req_reg[2]  = 5'd0;
    bus.req_data[2] = 32'h55;
    cyc();
    bus.req_valid = '0;
    #1;
    tests++;
    if (bus.rf_write_data_valid !== 1'b1 || bus.rf_write_register !== 5'd0 || bus.rf_write_data !== 32'h55) begin
      fails++; $display("FAIL r0_fwd: got v=%b r=%0d d=%h expected v=1 r=0 d=55",
                        bus.rf_write_data_valid, bus.rf_write_register, bus.rf_write_data);
    end
    cyc();
    #1;
    tests++; if (bus.wb_unreserved_err !== 1'b0) begin fails++; $display("FAIL r0_err: got %b expected 0", bus.wb_unreserved_err); end
    idle();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    bus.reserve_valid = 1'b1;
    bus.reserve_reg   = 5'd4;
    cyc();
    bus.reserve_valid = 1'b0;
    bus.req_valid     = 3'b010;
    bus.req_reg[1]    = 5'd4;
    bus.req_data[1]   = 32'hA5A5A5A5;
    cyc();
    rst = 1'b1;
    bus.req_valid   = 3'b111;
    bus.req_reg     = '0;
    bus.query_reg_1 = 5'd4;
    #1;
    tests++; if (bus.req_ready !== 3'b000) begin fails++; $display("FAIL rsti_req_ready: got %b expected 000", bus.req_ready); end
    cyc();
    rst = 1'b0;
    #1;
    tests++; if (bus.rf_write_data_valid !== 1'b0) begin fails++; $display("FAIL rsti_rf_valid: got %b expected 0", bus.rf_write_data_valid); end
    tests++; if (bus.query_busy_1 !== 1'b0) begin fails++; $display("FAIL rsti_busy: got %b expected 0", bus.query_busy_1); end
    tests++; if (bus.req_ready !== 3'b001) begin fails++; $display("FAIL rsti_grant: got %b expected 001", bus.req_ready); end
    idle();
  endtask

  task automatic test_random();
    bit          m_busy [32];
    int          m_ptr;
    bit          m_rfv;
    logic [4:0]  m_rfreg;
    logic [31:0] m_rfdata;
    bit          m_err;
    int          g;
    logic [2:0]  exp_ready;
    logic [4:0]  hs_reg;
    logic [31:0] hs_data;
    logic [4:0]  r;
    bit          exp_rr;

    do_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ptr = 0; m_rfv = 1'b0; m_rfreg = '0; m_rfdata = '0; m_err = 1'b0;

    for (int n = 0; n < 500; n++) begin
      bus.reserve_valid = 1'($urandom_range(0, 1));
      bus.reserve_reg   = 5'($urandom_range(0, 7));
      bus.query_reg_1   = 5'($urandom_range(0, 9));
      bus.query_reg_2   = 5'($urandom_range(0, 9));
      bus.req_valid     = 3'($urandom_range(0, 7));
      for (int k = 0; k < NR; k++) begin
        bus.req_reg[k]  = 5'($urandom_range(0, 7));
        bus.req_data[k] = $urandom;
      end
      #1;

      // Expected grant: first valid requester at or after m_ptr, wrapping.
      g = -1;
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && bus.req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
      exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
      hs_reg    = (g >= 0) ? bus.req_reg[g]  : 5'd0;
      hs_data   = (g >= 0) ? bus.req_data[g] : 32'd0;
      r         = bus.reserve_reg;
      exp_rr    = (r == 5'd0) ||
                  (!m_busy[r] && !(m_rfv && m_rfreg == r) && !(g >= 0 && hs_reg == r));

      tests++; if (bus.req_ready !== exp_ready) begin fails++; $display("FAIL rnd_grant[%0d]: got %b expected %b", n, bus.req_ready, exp_ready); end
      tests++; if (bus.query_busy_1 !== m_busy[bus.query_reg_1]) begin fails++; $display("FAIL rnd_qb1[%0d]: got %b expected %b", n, bus.query_busy_1, m_busy[bus.query_reg_1]); end
      tests++; if (bus.query_busy_2 !== m_busy[bus.query_reg_2]) begin fails++; $display("FAIL rnd_qb2[%0d]: got %b expected %b", n, bus.query_busy_2, m_busy[bus.query_reg_2]); end
      tests++; if (bus.reserve_ready !== exp_rr) begin fails++; $display("FAIL rnd_rsv_ready[%0d]: got %b expected %b", n, bus.reserve_ready, exp_rr); end
      tests++; if (bus.rf_write_data_valid !== m_rfv) begin fails++; $display("FAIL rnd_rf_valid[%0d]: got %b expected %b", n, bus.rf_write_data_valid, m_rfv); end
      tests++; if (bus.rf_write_register !== m_rfreg) begin fails++; $display("FAIL rnd_rf_reg[%0d]: got %0d expected %0d", n, bus.rf_write_register, m_rfreg); end
      tests++; if (bus.rf_write_data !== m_rfdata) begin fails++; $display("FAIL rnd_rf_data[%0d]: got %h expected %h", n, bus.rf_write_data, m_rfdata); end
      tests++; if (bus.wb_unreserved_err !== m_err) begin fails++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, bus.wb_unreserved_err, m_err); end

      // Advance the model by one clock edge.
      if (g >= 0 && hs_reg != 5'd0 && !m_busy[hs_reg]) m_err = 1'b1;
      if (m_rfv) m_busy[m_rfreg] = 1'b0;
      if (bus.reserve_valid && exp_rr && r != 5'd0) m_busy[r] = 1'b1;
      m_rfv = (g >= 0);
      if (g >= 0) begin
        m_rfreg  = hs_reg;
        m_rfdata = hs_data;
        m_ptr    = (g + 1) % NR;
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_reserve_query();
    test_round_robin();
    test_writeback_clear();
    test_unreserved_err();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, 3, number of write-back requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, 32, register data width.
REQ-003 SHALL have parameter REG_IDX_WIDTH, 5, register index width (32 registers).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port reserve_valid  input  1  issue stage requests to mark a destination pending.
REQ-007 SHALL have port reserve_reg  input  REG_IDX_WIDTH  destination to mark pending.
REQ-008 SHALL have port reserve_ready  output  1  reservation accepted this cycle.
REQ-009 SHALL have port query_reg_1, query_reg_2  input  REG_IDX_WIDTH  source operands to check.
REQ-010 SHALL have port query_busy_1, query_busy_2  output  1  operand has a pending write.
REQ-011 SHALL have port req_valid  input  NUM_REQ  per-requester write-back valid.
REQ-012 SHALL have port req_reg  input  NUM_REQ x REG_IDX_WIDTH  per-requester destination.
REQ-013 SHALL have port req_data  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-014 SHALL have port req_ready  output  NUM_REQ  one-hot grant; handshake = valid and ready.
REQ-015 SHALL have ports rf_write_register / rf_write_data / rf_write_data_valid  output  REG_IDX_WIDTH / DATA_WIDTH / 1  register-file write port.
REQ-016 SHALL have port wb_unreserved_err  output  1  sticky: write-back to a non-pending register occurred.

Function
REQ-017 Scoreboard SHALL hold one busy bit per register; register 0 SHALL always read not-busy.
REQ-018 query_busy_n SHALL be combinational: busy[query_reg_n].
REQ-019 reserve_ready SHALL be combinational: high when reserve_reg is not busy (always high for register 0).
REQ-020 On reserve_valid and reserve_ready, busy[reserve_reg] SHALL set at the next edge (no effect for register 0).
REQ-021 Arbiter SHALL grant at most one requester per cycle, round-robin, searching from pointer ptr upward with wrap modulo NUM_REQ.
REQ-022 req_ready SHALL be combinational and asserted only for the granted requester, and only when its req_valid is high.
REQ-023 After a grant to index g, ptr SHALL become (g+1) mod NUM_REQ; with no grant ptr SHALL hold.
REQ-024 A handshake SHALL register req_reg/req_data into rf_write_register/rf_write_data, with rf_write_data_valid high, exactly one cycle later (latency 1).
REQ-025 rf_write_data_valid SHALL be low in any cycle following a cycle with no handshake; rf_write_register/rf_write_data SHALL then hold their last values.
REQ-026 busy[rf_write_register] SHALL clear at the edge ending a cycle in which rf_write_data_valid is high.
REQ-027 A reservation of a register whose clear is in flight SHALL stall (reserve_ready low) until the clear has taken effect; set and clear SHALL never target the same bit in one cycle.
REQ-028 A handshake whose req_reg is non-zero and not busy SHALL still be forwarded and SHALL set wb_unreserved_err at the next edge; it SHALL stay set until reset.
REQ-029 Write-backs to register 0 SHALL be forwarded unchanged (the register file discards them) and SHALL NOT set wb_unreserved_err.

Reset
REQ-030 While rst is high at an edge: all busy bits 0, ptr 0, rf_write_data_valid 0, rf_write_register 0, rf_write_data 0, wb_unreserved_err 0.
REQ-031 req_ready and reserve_ready SHALL be 0 while rst is high; in-flight write-backs SHALL be discarded.

Structure
REQ-032 Package regfile_pkg SHALL hold DATA_WIDTH, NUM_REGISTERS, REG_IDX_WIDTH, and typedefs reg_idx_t and reg_data_t.
REQ-033 Round-robin arbitration SHALL be one sub-module, rr_arbiter (request vector in, one-hot grant out, internal pointer).

Verification
REQ-034 After reset, reserve r5, then query_reg_1=5 -> query_busy_1=1 next cycle; reserve_ready=0 for a second r5 reservation.
REQ-035 All three req_valid high continuously, distinct regs r1..r3 -> grants 0,1,2,0,... in consecutive cycles; rf write r1 appears one cycle after first grant.
REQ-036 Reserve r7, requester 1 writes r7 data 0xDEADBEEF -> rf_write_data_valid=1, rf_write_register=7, rf_write_data=0xDEADBEEF one cycle later; busy[7]=0 the cycle after.
REQ-037 Write-back to unreserved r9 -> forwarded, wb_unreserved_err=1 and remains 1; write-back to r0 -> no error.
REQ-038 Assert rst with a handshake pending -> next cycle rf_write_data_valid=0, all query_busy=0, next grant goes to requester 0.
